// File: rtl/gpr_pkg.sv
// Shared types and constants for the MIPS general-purpose register file.
package gpr_pkg;

  localparam int GPR_ADDR_W = 5;
  localparam int GPR_DATA_W = 32;
  localparam int REG_NUM    = 32;

  typedef logic [GPR_ADDR_W-1:0] reg_addr_t;
  typedef logic [GPR_DATA_W-1:0] reg_data_t;

  localparam reg_addr_t REG_ZERO_ADDR = '0;
  localparam reg_data_t ZERO_WORD     = '0;
  localparam logic      RST_EN        = 1'b0;

endpackage

// File: rtl/gpr_if.sv
// Writeback, ID read-port and load-scoreboard signals of the register file.
interface gpr_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);

  logic              WB_GPR_WE;
  logic [ADDR_W-1:0] WB_GPR_WADDR;
  logic [DATA_W-1:0] WB_GPR_WDATA;
  logic              RE1;
  logic              RE2;
  logic [ADDR_W-1:0] RADDR1;
  logic [ADDR_W-1:0] RADDR2;
  logic [DATA_W-1:0] RDATA1;
  logic [DATA_W-1:0] RDATA2;
  logic              SB_SET;
  logic [ADDR_W-1:0] SB_ADDR;
  logic              STALL_REQ;

  modport master (
    output WB_GPR_WE, WB_GPR_WADDR, WB_GPR_WDATA,
    output RE1, RE2, RADDR1, RADDR2, SB_SET, SB_ADDR,
    input  RDATA1, RDATA2, STALL_REQ
  );

  modport slave (
    input  WB_GPR_WE, WB_GPR_WADDR, WB_GPR_WDATA,
    input  RE1, RE2, RADDR1, RADDR2, SB_SET, SB_ADDR,
    output RDATA1, RDATA2, STALL_REQ
  );

endinterface

// File: rtl/gpr_scoreboard.sv
// Load-pending scoreboard: one bit per register, set by an issued load and
// cleared by its writeback; bit 0 never holds a pending load.
module gpr_scoreboard
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = GPR_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              set_en,
  input  logic [ADDR_W-1:0] set_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] look_addr1,
  input  logic [ADDR_W-1:0] look_addr2,
  output logic              pend1,
  output logic              pend2
);

  logic [NUM_REGS-1:0] pending_q;
  logic [NUM_REGS-1:0] pending_d;

  // Set is applied after clear so a newer load supersedes the retiring one.
  always_comb begin
    pending_d = pending_q;
    if (clr_en && clr_addr != '0) pending_d[clr_addr] = 1'b0;
    if (set_en && set_addr != '0) pending_d[set_addr] = 1'b1;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (RST == RST_EN) pending_q <= '0;
    else               pending_q <= pending_d;
  end

  assign pend1 = pending_q[look_addr1];
  assign pend2 = pending_q[look_addr2];

endmodule

// File: rtl/gpr_file.sv
// 32x32 MIPS register file: one writeback port, two bypassed ID read ports
// and a load-use stall request driven by the pending-load scoreboard.
module gpr_file
  import gpr_pkg::*;
#(
  parameter int NUM_REGS = REG_NUM,
  parameter int ADDR_W   = GPR_ADDR_W,
  parameter int DATA_W   = GPR_DATA_W
) (
  input  logic CLK,
  input  logic RST,
  gpr_if.slave bus
);

  logic [DATA_W-1:0] regs [NUM_REGS];
  logic              wr_en;
  logic              hit1;
  logic              hit2;
  logic              pend1;
  logic              pend2;

  assign wr_en = bus.WB_GPR_WE && (bus.WB_GPR_WADDR != '0);
  assign hit1  = bus.WB_GPR_WE && (bus.WB_GPR_WADDR == bus.RADDR1);
  assign hit2  = bus.WB_GPR_WE && (bus.WB_GPR_WADDR == bus.RADDR2);

  always_ff @(posedge CLK) begin
    if (RST == RST_EN) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[bus.WB_GPR_WADDR] <= bus.WB_GPR_WDATA;
    end
  end

  gpr_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W)
  ) u_sb (
    .CLK        (CLK),
    .RST        (RST),
    .set_en     (bus.SB_SET),
    .set_addr   (bus.SB_ADDR),
    .clr_en     (bus.WB_GPR_WE),
    .clr_addr   (bus.WB_GPR_WADDR),
    .look_addr1 (bus.RADDR1),
    .look_addr2 (bus.RADDR2),
    .pend1      (pend1),
    .pend2      (pend2)
  );

  // Write-through bypass lets ID consume the writeback value in the same cycle.
  always_comb begin
    bus.RDATA1    = '0;
    bus.RDATA2    = '0;
    bus.STALL_REQ = 1'b0;
    if (RST != RST_EN) begin
      if (bus.RE1 && bus.RADDR1 != '0) bus.RDATA1 = hit1 ? bus.WB_GPR_WDATA : regs[bus.RADDR1];
      if (bus.RE2 && bus.RADDR2 != '0) bus.RDATA2 = hit2 ? bus.WB_GPR_WDATA : regs[bus.RADDR2];
      bus.STALL_REQ = (bus.RE1 && pend1 && !hit1) || (bus.RE2 && pend2 && !hit2);
    end
  end

endmodule
